// File: rtl/timer_pkg.sv
// Shared constants for the timer counter/compare core: write-select encodings,
// counter width, compare reset value and the byte-merge helper.
package timer_pkg;

  localparam int          CNT_WIDTH   = 64;
  localparam int          HALF_WIDTH  = 32;
  localparam logic [63:0] CMP_RST_VAL = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic [2:0] SEL_CNT_LO = 3'd0;
  localparam logic [2:0] SEL_CNT_HI = 3'd1;
  localparam logic [2:0] SEL_CMP_LO = 3'd2;
  localparam logic [2:0] SEL_CMP_HI = 3'd3;
  localparam logic [2:0] SEL_INT_ST = 3'd4;
  localparam logic [2:0] SEL_INT_EN = 3'd5;

  typedef struct packed {
    logic        en;
    logic [2:0]  sel;
    logic [31:0] data;
    logic [3:0]  strb;
  } wr_req_t;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/timer_int_ctrl.sv
// Interrupt status/enable for the timer: level-set on match, W1C clear, set wins.
// TIMER_CMP_AUTO_CLR_EN adds the auto_clr control bit.
module timer_int_ctrl (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic match,
  input  logic st_clr,
  input  logic en_wr,
  input  logic en_d,
`ifdef TIMER_CMP_AUTO_CLR_EN
  input  logic ac_d,
  output logic auto_clr,
`endif
  output logic int_st,
  output logic int_en,
  output logic tim_int
);

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      int_st <= 1'b0;
      int_en <= 1'b0;
    end else begin
      if (match)       int_st <= 1'b1;
      else if (st_clr) int_st <= 1'b0;
      if (en_wr)       int_en <= en_d;
    end
  end

`ifdef TIMER_CMP_AUTO_CLR_EN
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n)  auto_clr <= 1'b0;
    else if (en_wr)  auto_clr <= ac_d;
  end
`endif

  assign tim_int = int_st & int_en;

endmodule

// File: rtl/timer_cnt_cmp.sv
// Timer 64-bit counter and compare datapath with byte-masked half writes.
// Optional periodic mode (auto-clear on match) under TIMER_CMP_AUTO_CLR_EN.
module timer_cnt_cmp
  import timer_pkg::*;
#(
  parameter int              CNT_W   = CNT_WIDTH,
  parameter logic [CNT_W-1:0] CMP_RST = CMP_RST_VAL
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             timer_en,
  input  logic             cnt_en,
  input  logic             halt_ack,
  input  logic             wr_en,
  input  logic [2:0]       wr_sel,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cmp,
  output logic             int_st,
  output logic             int_en,
  output logic             tim_int
`ifdef TIMER_CMP_AUTO_CLR_EN
  ,output logic            auto_clr
`endif
);

  localparam int HW = CNT_W / 2;

  wr_req_t                 wr_req;
  logic [1:0][HW-1:0]      cnt_q, cnt_nxt, cmp_q;
  logic                    timer_en_d;
  logic                    match;
  logic                    ac;

  assign wr_req = '{en: wr_en, sel: wr_sel, data: wdata, strb: wstrb};

  assign match = (cnt_q == cmp_q);
  assign cnt   = cnt_q;
  assign cmp   = cmp_q;

  // Write beats disable-clear beats halt beats tick; the untouched half holds.
  always_comb begin
    cnt_nxt = cnt_q;
    if (wr_req.en && wr_req.sel == SEL_CNT_LO)
      cnt_nxt[0] = byte_merge(cnt_q[0], wr_req.data, wr_req.strb);
    else if (wr_req.en && wr_req.sel == SEL_CNT_HI)
      cnt_nxt[1] = byte_merge(cnt_q[1], wr_req.data, wr_req.strb);
    else if (timer_en_d && !timer_en)
      cnt_nxt = '0;
    else if (halt_ack)
      cnt_nxt = cnt_q;
    else if (cnt_en && timer_en)
      cnt_nxt = (ac && match) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      cnt_q      <= '0;
      timer_en_d <= 1'b0;
    end else begin
      cnt_q      <= cnt_nxt;
      timer_en_d <= timer_en;
    end
  end

  for (genvar h = 0; h < 2; h++) begin : g_cmp
    localparam logic [2:0] SEL = (h == 0) ? SEL_CMP_LO : SEL_CMP_HI;
    always_ff @(posedge sys_clk) begin
      if (!sys_rst_n)
        cmp_q[h] <= CMP_RST[h*HW +: HW];
      else if (wr_req.en && wr_req.sel == SEL)
        cmp_q[h] <= byte_merge(cmp_q[h], wr_req.data, wr_req.strb);
    end
  end

  timer_int_ctrl u_int_ctrl (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .match     (match),
    .st_clr    (wr_req.en && wr_req.sel == SEL_INT_ST && wr_req.strb[0] && wr_req.data[0]),
    .en_wr     (wr_req.en && wr_req.sel == SEL_INT_EN && wr_req.strb[0]),
    .en_d      (wr_req.data[0]),
`ifdef TIMER_CMP_AUTO_CLR_EN
    .ac_d      (wr_req.data[1]),
    .auto_clr  (auto_clr),
`endif
    .int_st    (int_st),
    .int_en    (int_en),
    .tim_int   (tim_int)
  );

`ifdef TIMER_CMP_AUTO_CLR_EN
  assign ac = auto_clr;
`else
  assign ac = 1'b0;
`endif

endmodule

// File: tb/tb_timer_cnt_cmp.sv
// Directed self-checking bench for timer_cnt_cmp; inputs driven and outputs
// sampled 1ns after each rising edge.
module tb_timer_cnt_cmp;
  import timer_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n, timer_en, cnt_en, halt_ack, wr_en;
  logic [2:0]  wr_sel;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [63:0] cnt, cmp;
  logic        int_st, int_en, tim_int;
`ifdef TIMER_CMP_AUTO_CLR_EN
  logic        auto_clr;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 sys_clk = ~sys_clk;

  timer_cnt_cmp dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .timer_en  (timer_en),
    .cnt_en    (cnt_en),
    .halt_ack  (halt_ack),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wdata     (wdata),
    .wstrb     (wstrb),
    .cnt       (cnt),
    .cmp       (cmp),
    .int_st    (int_st),
    .int_en    (int_en),
    .tim_int   (tim_int)
`ifdef TIMER_CMP_AUTO_CLR_EN
    ,.auto_clr (auto_clr)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_sel = sel; wdata = d; wstrb = s;
    step();
    wr_en = 1'b0;
  endtask

  task automatic tick();
    cnt_en = 1'b1;
    step();
    cnt_en = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b0; timer_en = 1'b0; cnt_en = 1'b0; halt_ack = 1'b0;
    wr_en = 1'b0; wr_sel = '0; wdata = '0; wstrb = '0;
    step(); step();
    chk("rst_cnt", cnt, 64'h0);
    chk("rst_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst_int", {int_st, int_en, tim_int}, 64'h0);

    // reset and count
    sys_rst_n = 1'b1; timer_en = 1'b1;
    step();
    repeat (5) tick();
    chk("cnt5", cnt, 64'd5);
    chk("cnt5_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("cnt5_st", int_st, 64'd0);

    // compare and interrupt
    wr(SEL_CNT_LO, 32'h0, 4'hF);
    chk("cnt_clr_wr", cnt, 64'd0);
    wr(SEL_CMP_LO, 32'd3, 4'hF);
    chk("cmp_lo", cmp, 64'hFFFF_FFFF_0000_0003);
    wr(SEL_CMP_HI, 32'd0, 4'hF);
    chk("cmp_hi", cmp, 64'd3);
    wr(SEL_INT_EN, 32'd1, 4'h1);
    chk("int_en_set", int_en, 64'd1);
    tick(); tick(); tick();
    chk("cnt3", cnt, 64'd3);
    chk("st_before", int_st, 64'd0);
    step();
    chk("st_match", int_st, 64'd1);
    chk("tim_int_match", tim_int, 64'd1);
    wr(SEL_INT_ST, 32'd1, 4'h1);
    chk("set_wins", int_st, 64'd1);
    tick();
    chk("cnt4", cnt, 64'd4);
    wr(SEL_INT_ST, 32'd1, 4'h1);
    chk("w1c_st", int_st, 64'd0);
    chk("w1c_tim", tim_int, 64'd0);
    wr(SEL_INT_EN, 32'd0, 4'h0);
    chk("int_en_nostrb", int_en, 64'd1);
    wr(3'd6, 32'hDEAD_BEEF, 4'hF);
    wr(3'd7, 32'hDEAD_BEEF, 4'hF);
    chk("sel67_cnt", cnt, 64'd4);
    chk("sel67_cmp", cmp, 64'd3);

    // wrap
    wr(SEL_CNT_LO, 32'hFFFF_FFFF, 4'hF);
    wr(SEL_CNT_HI, 32'hFFFF_FFFF, 4'hF);
    chk("cnt_ones", cnt, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    chk("wrap", cnt, 64'd0);
    step();
    chk("wrap_st", int_st, 64'd0);

    // halt: counter frozen, writes and matching continue
    wr(SEL_CNT_LO, 32'd10, 4'hF);
    chk("cnt10", cnt, 64'd10);
    halt_ack = 1'b1;
    repeat (4) tick();
    chk("halt_hold", cnt, 64'd10);
    wr(SEL_CMP_LO, 32'd10, 4'hF);
    chk("halt_cmp_wr", cmp, 64'd10);
    step();
    chk("halt_match", int_st, 64'd1);
    wr(SEL_INT_ST, 32'd1, 4'h1);
    chk("halt_reassert", int_st, 64'd1);
    halt_ack = 1'b0;
    timer_en = 1'b0;
    step();
    chk("dis_clr", cnt, 64'd0);
    wr(SEL_INT_ST, 32'd1, 4'h1);
    chk("dis_w1c", int_st, 64'd0);

    // write priority over tick, byte masking, half independence
    timer_en = 1'b1;
    step();
    cnt_en = 1'b1;
    wr(SEL_CNT_LO, 32'h0000_0100, 4'b0010);
    cnt_en = 1'b0;
    chk("wr_prio", cnt, 64'h0000_0000_0000_0100);
    wr(SEL_CNT_LO, 32'h0000_0055, 4'b0001);
    chk("wr_byte0", cnt, 64'h0000_0000_0000_0155);
    cnt_en = 1'b1;
    wr(SEL_CNT_HI, 32'h1234_5678, 4'hF);
    cnt_en = 1'b0;
    chk("wr_hi", cnt, 64'h1234_5678_0000_0155);

    // reset mid-count discards pending write
    sys_rst_n = 1'b0; cnt_en = 1'b1;
    wr(SEL_CMP_LO, 32'd5, 4'hF);
    cnt_en = 1'b0;
    chk("rst2_cnt", cnt, 64'd0);
    chk("rst2_cmp", cmp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rst2_en", int_en, 64'd0);
    sys_rst_n = 1'b1;
    step();

    // periodic mode / free-running
    wr(SEL_CMP_LO, 32'd2, 4'hF);
    wr(SEL_CMP_HI, 32'd0, 4'hF);
    wr(SEL_INT_EN, 32'd3, 4'h1);
    chk("ie_after", int_en, 64'd1);
`ifdef TIMER_CMP_AUTO_CLR_EN
    chk("auto_clr", auto_clr, 64'd1);
    begin
      logic [63:0] seq [7] = '{64'd1, 64'd2, 64'd0, 64'd1, 64'd2, 64'd0, 64'd1};
      for (int i = 0; i < 7; i++) begin
        tick();
        chk($sformatf("ac_seq%0d", i), cnt, seq[i]);
      end
    end
`else
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("free_seq%0d", i), cnt, 64'(i + 1));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_cnt_cmp.md
# timer_cnt_cmp

Counter and compare core of the timer IP, downstream of the `counter_ctrl` prescaler. It consumes the prescaler's `cnt_en` tick and `halt_ack` status. It maintains a 64-bit up-counter and a 64-bit compare value, both software-writable. It raises a maskable, write-1-to-clear interrupt on counter/compare equality.

## Interface
Parameters:
- `CNT_W`, 64: counter and compare width. Fixed at 64; splits into two 32-bit halves.
- `CMP_RST`, 64'hFFFF_FFFF_FFFF_FFFF: reset value of the compare register.

Ports:
- `sys_clk` in 1: the single clock.
- `sys_rst_n` in 1: reset. Synchronous, active-low; sampled only on the `sys_clk` rising edge.
- `timer_en` in 1: timer enable from the control register.
- `cnt_en` in 1: single-cycle count tick from the prescaler.
- `halt_ack` in 1: debug halt is in effect.
- `wr_en` in 1: register write strobe, one cycle per write.
- `wr_sel` in 3: write target. 0 = CNT_LO, 1 = CNT_HI, 2 = CMP_LO, 3 = CMP_HI, 4 = INT_ST, 5 = INT_EN, 6–7 = ignored.
- `wdata` in 32: write data.
- `wstrb` in 4: byte enables for `wdata`.
- `cnt` out 64: current counter value.
- `cmp` out 64: current compare value.
- `int_st` out 1: raw interrupt status.
- `int_en` out 1: interrupt enable.
- `tim_int` out 1: interrupt output, equal to `int_st & int_en`.

## Operation
- Reset values: `cnt` = 0, `cmp` = `CMP_RST`, `int_st` = 0, `int_en` = 0, `tim_int` = 0. The internal `timer_en_d` register also resets to 0.
- Counter next-state, in priority order:
  1. A write to CNT_LO or CNT_HI loads the enabled bytes. Other bytes hold.
  2. On a `timer_en` falling edge (`timer_en_d & ~timer_en`), `cnt` clears to 0.
  3. When `halt_ack` is high, `cnt` holds. This applies even if `cnt_en` is high.
  4. When `cnt_en & timer_en` is high, `cnt` ← `cnt` + 1.
  5. Otherwise `cnt` holds.
- A write to one half of the counter never disturbs the other half in the same cycle. The increment is suppressed in the write cycle.
- Wrap-around: `cnt` = 64'hFFFF_FFFF_FFFF_FFFF plus a tick gives 0. No overflow flag is produced.
- Compare register: CMP_LO and CMP_HI writes are byte-masked by `wstrb`. They are unaffected by `timer_en` and by halt.
- Match: `match = (cnt == cmp)`, evaluated every cycle on the registered values. It is a level condition, not an edge.
- `int_st` next-state:
  - `match` high sets it to 1.
  - Otherwise, a write to INT_ST with `wstrb[0]` set and `wdata[0]` = 1 clears it to 0.
  - Otherwise it holds.
  - If a set and a clear occur in the same cycle, the set wins.
- `int_en`: written from `wdata[0]` when `wr_sel` = 5 and `wstrb[0]` is set.
- Halt: while `halt_ack` is high, register writes are still accepted and match detection continues. A frozen counter that equals `cmp` keeps re-asserting `int_st`.
- Writes with `wr_sel` 6 or 7 have no effect.

## Timing
- All state updates on the `sys_clk` rising edge. No combinational path from `wr_*` to any output.
- Register write → visible on `cnt`, `cmp` or `int_en` one cycle later.
- Tick → `cnt` increments one cycle later.
- `cnt` reaches `cmp` in cycle N → `int_st` is high in cycle N+1 → `tim_int` is high in N+1 if `int_en` is set. `tim_int` is combinational from the registered `int_st` and `int_en`.
- `timer_en` falls in cycle N → `cnt` = 0 in cycle N+1.
- Reset asserted mid-count → all state takes its reset value on the next edge. Any pending write is discarded.

## Configuration
- Macro: `TIMER_CMP_AUTO_CLR_EN`.
- Defined:
  - `INT_EN` bit 1 is an `auto_clr` control bit: writable, reset value 0, and reflected on output port `auto_clr` (out 1).
  - When `auto_clr` = 1 and a tick arrives while `match` is high, `cnt` goes to 0 instead of `cnt` + 1. This gives a periodic timer with period `cmp` + 1 ticks.
  - Counter writes and clear-on-disable keep their higher priority.
- Undefined:
  - The counter is free-running.
  - `INT_EN` bit 1 reads as 0, writes to it are ignored, and the `auto_clr` port is absent.

## Structure
- Package `timer_pkg` holds:
  - the `wr_sel` encodings as constants (`SEL_CNT_LO` … `SEL_INT_EN`);
  - `CMP_RST`;
  - the counter width.
- One sub-module, `timer_int_ctrl`. It holds `int_st`, `int_en` and (when configured) `auto_clr` with the W1C and set-priority logic, and generates `tim_int`.
- The counter and compare datapath, with its byte-masked half writes, stays in the top module.

## Test plan
- **Reset and count:** release reset; hold `timer_en` = 1 and pulse `cnt_en` 5 times → `cnt` = 5, `cmp` = all ones, `int_st` = 0.
- **Compare and interrupt:**
  - Write CMP_LO = 3 and CMP_HI = 0, set `int_en` = 1, then tick 3 times → `int_st` and `tim_int` are high the cycle after `cnt` = 3.
  - Write 1 to INT_ST while `cnt` = 4 → `int_st` = 0 and `tim_int` = 0.
  - Write 1 to INT_ST while `cnt` = 3 with no tick → `int_st` stays 1 (set wins).
- **Wrap:** write CNT_LO = CNT_HI = 32'hFFFF_FFFF, then one tick → `cnt` = 0, and `int_st` does not change unless `cmp` = 0.
- **Halt and disable:**
  - With `cnt` = 10, hold `halt_ack` = 1 while pulsing `cnt_en` 4 times → `cnt` stays 10.
  - Then drop `timer_en` → `cnt` = 0 one cycle later.
- **Write priority:** in the same cycle, tick and write CNT_LO = 32'h0000_0100 with `wstrb` = 4'b0010 → CNT_LO becomes 32'h0000_0100 (byte 1 loaded, other bytes held), with no increment.
- **Auto-clear (`TIMER_CMP_AUTO_CLR_EN` defined):** set `cmp` = 2 and `auto_clr` = 1, then tick 7 times → `cnt` sequence is 1, 2, 0, 1, 2, 0, 1.
